// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter: per-source FIFOs, round-robin grant onto one register write port.
// Latency: accept at E0, write port registered at E1, register set captures at E2.
// Backpressure: per-source ready = FIFO not full; no same-edge pass-through.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_a_valid,
  output logic                     o_a_ready,
  input  logic [ADDR_W-1:0]        i_a_addr,
  input  logic [DATA_W-1:0]        i_a_data,
  input  logic                     i_b_valid,
  output logic                     o_b_ready,
  input  logic [ADDR_W-1:0]        i_b_addr,
  input  logic [DATA_W-1:0]        i_b_data,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [DATA_W-1:0]        o_wr_data,
  output logic                     o_wr_wren,
  output logic [(1<<ADDR_W)-1:0]   o_pending,
  output logic                     o_idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t           mem_a [FIFO_DEPTH];
  wb_t           mem_b [FIFO_DEPTH];
  logic [PW-1:0] wp_a, rp_a, wp_b, rp_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          run;
  logic          rr;
  logic          acc_a, acc_b, push_a, push_b;
  logic          ne_a, ne_b, gnt_a, gnt_b;

  // run keeps ready low until the first edge after reset release
  assign o_a_ready = run && (cnt_a != CW'(FIFO_DEPTH));
  assign o_b_ready = run && (cnt_b != CW'(FIFO_DEPTH));

  assign acc_a  = i_a_valid && o_a_ready;
  assign acc_b  = i_b_valid && o_b_ready;
  // x0 writes complete the handshake but are dropped here
  assign push_a = acc_a && (i_a_addr != '0);
  assign push_b = acc_b && (i_b_addr != '0);

  assign ne_a  = (cnt_a != '0);
  assign ne_b  = (cnt_b != '0);
  assign gnt_a = ne_a && (!ne_b || !rr);
  assign gnt_b = ne_b && !gnt_a;

  assign o_idle = !ne_a && !ne_b && !o_wr_wren;

  always_ff @(posedge i_clk) begin
    if (push_a) mem_a[wp_a] <= {i_a_addr, i_a_data};
    if (push_b) mem_b[wp_b] <= {i_b_addr, i_b_data};
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      run       <= 1'b0;
      rr        <= 1'b0;
      wp_a      <= '0;
      rp_a      <= '0;
      cnt_a     <= '0;
      wp_b      <= '0;
      rp_b      <= '0;
      cnt_b     <= '0;
      o_wr_wren <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      run <= 1'b1;
      if (push_a) wp_a <= wp_a + 1'b1;
      if (gnt_a)  rp_a <= rp_a + 1'b1;
      cnt_a <= cnt_a + CW'(push_a) - CW'(gnt_a);
      if (push_b) wp_b <= wp_b + 1'b1;
      if (gnt_b)  rp_b <= rp_b + 1'b1;
      cnt_b <= cnt_b + CW'(push_b) - CW'(gnt_b);

      // rr points away from whoever was just served
      if (gnt_a || gnt_b) rr <= gnt_a;

      o_wr_wren <= gnt_a || gnt_b;
      if (gnt_a) begin
        o_wr_addr <= mem_a[rp_a].addr;
        o_wr_data <= mem_a[rp_a].data;
      end else if (gnt_b) begin
        o_wr_addr <= mem_b[rp_b].addr;
        o_wr_data <= mem_b[rp_b].data;
      end
    end
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < cnt_a) o_pending[mem_a[rp_a + PW'(i)].addr] = 1'b1;
      if (CW'(i) < cnt_b) o_pending[mem_b[rp_b + PW'(i)].addr] = 1'b1;
    end
    if (o_wr_wren) o_pending[o_wr_addr] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: directed write-back sequences, monitor checks write port.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_a_valid = 1'b0, i_b_valid = 1'b0;
  logic [4:0]  i_a_addr = '0, i_b_addr = '0;
  logic [31:0] i_a_data = '0, i_b_data = '0;
  logic        o_a_ready, o_b_ready, o_wr_wren, o_idle;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data, o_pending;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_wr_wren(o_wr_wren),
    .o_pending(o_pending), .o_idle(o_idle)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] rf [32] = '{default: 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] ad, input logic [31:0] d);
    wr_t e;
    e.addr = ad;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // register-set model: raw storage so a stray x0 write would show up
  always @(posedge i_clk)
    if (i_rst && o_wr_wren) rf[o_wr_addr] <= o_wr_data;

  always @(negedge i_clk) begin : monitor
    wr_t e;
    if (i_rst && o_wr_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected none", o_wr_addr, o_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'h0, o_wr_addr}, {27'h0, e.addr});
        chk("wr_data", o_wr_data, e.data);
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send_a(input logic [4:0] ad, input logic [31:0] d);
    int t = 0;
    i_a_valid = 1'b1; i_a_addr = ad; i_a_data = d;
    while (!o_a_ready && t < 50) begin @(negedge i_clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout: ready got 0 expected 1");
    end
    @(negedge i_clk);
    i_a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] ad, input logic [31:0] d);
    int t = 0;
    i_b_valid = 1'b1; i_b_addr = ad; i_b_data = d;
    while (!o_b_ready && t < 50) begin @(negedge i_clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout: ready got 0 expected 1");
    end
    @(negedge i_clk);
    i_b_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #2 i_rst = 1'b0;
    #10;
    chk("rst_a_ready", {31'h0, o_a_ready}, 32'h0);
    chk("rst_b_ready", {31'h0, o_b_ready}, 32'h0);
    chk("rst_wren", {31'h0, o_wr_wren}, 32'h0);
    chk("rst_addr", {27'h0, o_wr_addr}, 32'h0);
    chk("rst_data", o_wr_data, 32'h0);
    chk("rst_pending", o_pending, 32'h0);
    chk("rst_idle", {31'h0, o_idle}, 32'h1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("post_rst_a_ready", {31'h0, o_a_ready}, 32'h1);
    chk("post_rst_b_ready", {31'h0, o_b_ready}, 32'h1);

    // single A write, latency and pending window
    expect_wr(5, 32'hDEADBEEF);
    send_a(5, 32'hDEADBEEF);
    chk("t1_pending_e0", o_pending, 32'h1 << 5);
    chk("t1_wren_e0", {31'h0, o_wr_wren}, 32'h0);
    @(negedge i_clk);
    chk("t1_wren_e1", {31'h0, o_wr_wren}, 32'h1);
    chk("t1_pending_e1", o_pending, 32'h1 << 5);
    @(negedge i_clk);
    chk("t1_wren_e2", {31'h0, o_wr_wren}, 32'h0);
    chk("t1_pending_e2", o_pending, 32'h0);
    chk("t1_idle", {31'h0, o_idle}, 32'h1);
    chk("t1_rf5", rf[5], 32'hDEADBEEF);

    // both saturated: alternation and B backpressure
    do_reset();
    expect_wr(1,  32'hA1); expect_wr(10, 32'hB1);
    expect_wr(2,  32'hA2); expect_wr(11, 32'hB2);
    expect_wr(3,  32'hA3); expect_wr(12, 32'hB3);
    fork
      begin send_a(1, 32'hA1); send_a(2, 32'hA2); send_a(3, 32'hA3); end
      begin send_b(10, 32'hB1); send_b(11, 32'hB2); send_b(12, 32'hB3); end
      begin
        repeat (2) @(negedge i_clk);
        chk("t2_b_ready_full", {31'h0, o_b_ready}, 32'h0);
        @(negedge i_clk);
        chk("t2_b_ready_after_pop", {31'h0, o_b_ready}, 32'h1);
      end
    join
    repeat (8) @(negedge i_clk);
    chk("t2_drained", exp_q.size(), 32'h0);
    chk("t2_idle", {31'h0, o_idle}, 32'h1);
    chk("t2_rf12", rf[12], 32'hB3);

    // x0 write is accepted and dropped
    send_a(0, 32'hFFFFFFFF);
    chk("t4_pending", o_pending, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t4_wren", {31'h0, o_wr_wren}, 32'h0);
      chk("t4_pending_hold", o_pending, 32'h0);
    end
    chk("t4_rf0", rf[0], 32'h0);

    // reset mid-stream discards queued writes
    do_reset();
    expect_wr(20, 32'hC0);
    fork
      begin send_a(20, 32'hC0); send_a(21, 32'hC1); end
      begin send_b(22, 32'hD0); send_b(23, 32'hD1); end
    join
    #2 i_rst = 1'b0;
    #1;
    chk("t5_wren", {31'h0, o_wr_wren}, 32'h0);
    chk("t5_pending", o_pending, 32'h0);
    chk("t5_idle", {31'h0, o_idle}, 32'h1);
    chk("t5_a_ready", {31'h0, o_a_ready}, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("t5_no_write", {31'h0, o_wr_wren}, 32'h0);
    end
    chk("t5_drained", exp_q.size(), 32'h0);
    chk("t5_idle_after", {31'h0, o_idle}, 32'h1);

    // same register from both sources
    do_reset();
    expect_wr(7, 32'h11);
    expect_wr(7, 32'h22);
    fork
      send_a(7, 32'h11);
      send_b(7, 32'h22);
    join
    chk("t6_pending_q", o_pending, 32'h1 << 7);
    @(negedge i_clk);
    chk("t6_pending_wa", o_pending, 32'h1 << 7);
    @(negedge i_clk);
    chk("t6_pending_wb", o_pending, 32'h1 << 7);
    @(negedge i_clk);
    chk("t6_pending_clear", o_pending, 32'h0);
    chk("t6_idle", {31'h0, o_idle}, 32'h1);
    chk("t6_rf7", rf[7], 32'h22);

    chk("final_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
